// File: rtl/led_pkg.sv
// led_pkg: shared defaults and helpers for the LED fade PWM stage.
package led_pkg;
  localparam int PWM_BITS_DEF = 8;
  localparam int STEP_CYC_DEF = 19531;
  localparam int LED_NUM = 4;
  function automatic int dmax_of(input int bits);
    return (1 << bits) - 1;
  endfunction
endpackage

// File: rtl/led_fade_pwm_if.sv
// led_fade_pwm_if: pattern in, PWM drive and busy out.
interface led_fade_pwm_if
  import led_pkg::*;
  ();
  logic [LED_NUM-1:0] led_in;
  logic               fade_en;
  logic [LED_NUM-1:0] led_out;
  logic               busy;
  modport master (output led_in, fade_en, input led_out, busy);
  modport slave (input led_in, fade_en, output led_out, busy);
endinterface

// File: rtl/led_fade_chan.sv
// led_fade_chan: one channel duty ramp/snap, PWM compare and output flop.
module led_fade_chan
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tgt_on,
  input  logic                fade_en,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                mismatch
);
  localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(dmax_of(PWM_BITS));
  logic [PWM_BITS-1:0] target, duty_q, duty_d;
  logic                led_q;
  always_comb begin
    target = tgt_on ? DMAX : '0;
    duty_d = !fade_en ? target :
             !tick ? duty_q :
             duty_q < target ? duty_q + 1'b1 :
             duty_q > target ? duty_q - 1'b1 : duty_q;
  end
  assign mismatch = duty_q != target;
  assign led = led_q;
  // Full duty is forced on so the pwm_cnt==DMAX slot never blinks off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      led_q  <= (duty_q == DMAX) | (pwm_cnt < duty_q);
    end
  end
endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: cross-fading PWM driver for the flow-LED pattern.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int                PWM_BITS = PWM_BITS_DEF,
  parameter int                STEP_W   = 16,
  parameter logic [STEP_W-1:0] STEP_CYC = STEP_W'(STEP_CYC_DEF)
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  led_fade_pwm_if.slave bus
);
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                tick, busy_q;
  logic [LED_NUM-1:0]  led, mismatch;
  always_comb begin
    tick       = step_cnt_q == STEP_CYC - STEP_W'(1);
    step_cnt_d = tick ? '0 : step_cnt_q + 1'b1;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      busy_q     <= |mismatch;
    end
  end
  for (genvar i = 0; i < LED_NUM; i++) begin : g_chan
    led_fade_chan #(.PWM_BITS(PWM_BITS)) u_chan (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .tgt_on  (bus.led_in[i]),
      .fade_en (bus.fade_en),
      .tick    (tick),
      .pwm_cnt (pwm_cnt_q),
      .led     (led[i]),
      .mismatch(mismatch[i])
    );
  end
  assign bus.led_out = led;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: scoreboard bench against a per-cycle duty/phase model.
module tb_led_fade_pwm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int d[4];
  int k = 0;
  logic [4:0] sb[$];
  led_fade_pwm_if bus();
  led_fade_pwm #(.PWM_BITS(4), .STEP_W(16), .STEP_CYC(16'd3)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus)
  );
  always #10 clk = ~clk;
  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1);
  end
  always @(posedge clk) begin
    logic [4:0] e;
    #1;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.led_out, bus.busy} !== e) begin
        errors++;
        $display("FAIL cycle t=%0t: got led_out=%b busy=%b required led_out=%b busy=%b",
                 $time, bus.led_out, bus.busy, e[4:1], e[0]);
      end
    end
  end
  task automatic cyc(input logic [3:0] li, input logic fe);
    logic [3:0] le;
    logic b;
    int t;
    bus.led_in = li;
    bus.fade_en = fe;
    b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = li[i] ? 15 : 0;
      le[i] = (d[i] == 15) || ((k % 16) < d[i]);
      b |= (d[i] != t);
      if (!fe) d[i] = t;
      else if (k % 3 == 2) d[i] = d[i] < t ? d[i] + 1 : d[i] > t ? d[i] - 1 : d[i];
    end
    sb.push_back({le, b});
    k++;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic hold(input logic [3:0] li, input logic fe, input int n);
    for (int j = 0; j < n; j++) cyc(li, fe);
  endtask
  task automatic do_reset(input logic [3:0] li, input logic fe);
    #3;
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (bus.led_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_led: got %b required 0000", bus.led_out);
    end
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b required 0", bus.busy);
    end
    bus.led_in = li;
    bus.fade_en = fe;
    @(negedge clk);
    sb.delete();
    for (int i = 0; i < 4; i++) d[i] = 0;
    k = 0;
    rst_n = 1'b1;
  endtask
  initial begin
    int guard;
    bus.led_in = 4'b0000;
    bus.fade_en = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 0;
    @(negedge clk);
    @(negedge clk);
    do_reset(4'b0000, 1'b1);
    hold(4'b0000, 1'b1, 20);
    hold(4'b0001, 1'b1, 70);
    hold(4'b0010, 1'b1, 70);
    guard = 0;
    while (d[0] != 6 && guard < 200) begin
      cyc(4'b0001, 1'b1);
      guard++;
    end
    checks++;
    if (d[0] != 6) begin
      errors++;
      $display("FAIL reversal_setup: got duty=%0d required 6", d[0]);
    end
    hold(4'b0000, 1'b1, 60);
    hold(4'b1010, 1'b0, 40);
    hold(4'b0000, 1'b0, 40);
    hold(4'b1111, 1'b1, 10);
    do_reset(4'b0000, 1'b1);
    hold(4'b0000, 1'b1, 10);
    for (int s = 0; s < 50; s++) begin
      if (s == 25) do_reset(4'($urandom_range(0, 15)), 1'b1);
      hold(4'($urandom_range(0, 15)), $urandom_range(0, 4) != 0, $urandom_range(1, 60));
    end
    hold(bus.led_in, bus.fade_en, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
